// File: rtl/control_sequencer.sv
// Hardwired control unit: one state per clock, fetch T0-T2, execute T3-T7.
// Datapath strobes are decoded from the state register and the opcode latched in T3.
module control_sequencer #(
    parameter int              OPW    = 5,
    parameter logic [OPW-1:0]  ADD_OP = OPW'(5'b00011)
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic [31:0]    IR,
    input  logic           CON_FF,
    input  logic           Stop,
    output logic [OPW-1:0] opcode,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zin,
    output logic           Zlowout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Cout,
    output logic           CONin,
    output logic           Write,
    output logic           Run
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t         state, nxt;
    logic [OPW-1:0] op_q, cur_op;
    logic           is_ld, is_ldi, is_st, is_mem, is_r, is_addi, is_br, is_halt;
    logic           unused_ir;

    assign unused_ir = ^IR[31-OPW:0];

    // IR is only valid from T3 on; hold the opcode for the rest of execute.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == S_T3)
                op_q <= IR[31 -: OPW];
        end
    end

    assign cur_op  = (state == S_T3) ? IR[31 -: OPW] : op_q;
    assign is_ld   = (cur_op == OP_LD);
    assign is_ldi  = (cur_op == OP_LDI);
    assign is_st   = (cur_op == OP_ST);
    assign is_mem  = is_ld | is_ldi | is_st;
    assign is_r    = (cur_op >= OP_ADD) && (cur_op <= OP_OR);
    assign is_addi = (cur_op == OP_ADDI);
    assign is_br   = (cur_op == OP_BR);
    assign is_halt = (cur_op == OP_HALT);

    always_comb begin
        state_t boundary;
        boundary = Stop ? S_HALT : S_T0;
        nxt      = state;
        case (state)
            S_IDLE: nxt = S_T0;
            S_T0:   nxt = S_T1;
            S_T1:   nxt = S_T2;
            S_T2:   nxt = S_T3;
            S_T3: begin
                if (is_halt)                                nxt = S_HALT;
                else if (is_mem || is_r || is_addi || is_br) nxt = S_T4;
                else                                        nxt = boundary;
            end
            S_T4:   nxt = S_T5;
            S_T5:   nxt = (is_ld || is_st || is_br) ? S_T6 : boundary;
            S_T6:   nxt = (is_ld || is_st) ? S_T7 : boundary;
            S_T7:   nxt = boundary;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        opcode  = '0;
        PCout   = 1'b0; MARin  = 1'b0; IncPC = 1'b0; Zin   = 1'b0;
        Zlowout = 1'b0; PCin   = 1'b0; Read  = 1'b0; MDRin = 1'b0;
        MDRout  = 1'b0; IRin   = 1'b0; Yin   = 1'b0;
        Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0; Rin   = 1'b0;
        Rout    = 1'b0; BAout  = 1'b0; Cout  = 1'b0; CONin = 1'b0;
        Write   = 1'b0;
        Run     = (state != S_IDLE) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_mem) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_r || is_addi) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
            end
            S_T4: begin
                if (is_mem || is_addi) begin
                    Cout = 1'b1; opcode = ADD_OP; Zin = 1'b1;
                end else if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; opcode = cur_op; Zin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_ldi || is_r || is_addi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; opcode = ADD_OP; Zin = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: expected per-cycle control words are queued, then popped and
// compared against {Run, opcode, strobes} one cycle at a time.
module tb_control_sequencer;

    logic        Clock, clear, CON_FF, Stop;
    logic [31:0] IR;
    logic [4:0]  opcode;
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Write, Run;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .opcode(opcode), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin), .Write(Write),
        .Run(Run)
    );

    localparam logic [19:0] PCOUT = 20'h00001, MARIN = 20'h00002, INCPC = 20'h00004,
        ZIN = 20'h00008, ZLOW = 20'h00010, PCIN = 20'h00020, READ = 20'h00040,
        MDRIN = 20'h00080, MDROUT = 20'h00100, IRIN = 20'h00200, YIN = 20'h00400,
        GRA = 20'h00800, GRB = 20'h01000, GRC = 20'h02000, RIN = 20'h04000,
        ROUT = 20'h08000, BAOUT = 20'h10000, COUT = 20'h20000, CONIN = 20'h40000,
        WRITE = 20'h80000;
    localparam logic [4:0]  ADD = 5'b00011;
    localparam logic [25:0] OFF = 26'h0;

    logic [25:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    wire [19:0] strobes = {Write, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra, Yin,
                           IRin, MDRout, MDRin, Read, PCin, Zlowout, Zin, IncPC, MARin, PCout};
    wire [25:0] actual  = {Run, opcode, strobes};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [25:0] ev(input logic [19:0] s, input logic [4:0] op);
        return {1'b1, op, s};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 27'h0123456};
    endfunction

    task automatic chk(input string tag, input logic [25:0] exp);
        checks++;
        assert (actual === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, actual, exp, $time);
        end
    endtask

    task automatic push_fetch();
        sb.push_back(ev(PCOUT | MARIN | INCPC | ZIN, 5'd0));
        sb.push_back(ev(ZLOW | PCIN | READ | MDRIN, 5'd0));
        sb.push_back(ev(MDROUT | IRIN, 5'd0));
    endtask

    task automatic push_off(input int n);
        for (int i = 0; i < n; i++) sb.push_back(OFF);
    endtask

    // IR/CON_FF for this instruction are applied once T0 is observed, so the
    // previous instruction's last state still sees its own IR.
    task automatic exec(input logic [31:0] ir_v, input logic con_v, input string tag);
        bit first = 1'b1;
        while (sb.size() != 0) begin
            @(posedge Clock); #2;
            chk(tag, sb.pop_front());
            if (first) begin
                IR = ir_v; CON_FF = con_v; first = 1'b0;
            end
        end
    endtask

    task automatic clear_pulse(input string tag);
        @(negedge Clock); clear = 1'b0;
        #1 chk(tag, OFF);
        @(negedge Clock); clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
        #12 chk("reset_idle", OFF);
        @(posedge Clock); #2 chk("reset_held", OFF);
        @(negedge Clock); clear = 1'b1;

        // st: Write only in cycle 8, MDRin with Rout in cycle 7
        push_fetch();
        sb.push_back(ev(GRB | BAOUT | YIN, 5'd0));
        sb.push_back(ev(COUT | ZIN, ADD));
        sb.push_back(ev(ZLOW | MARIN, 5'd0));
        sb.push_back(ev(GRA | ROUT | MDRIN, 5'd0));
        sb.push_back(ev(WRITE, 5'd0));
        exec(32'h10900000, 1'b0, "st");

        // sub: 6 cycles, ALU opcode passed through from IR
        push_fetch();
        sb.push_back(ev(GRB | ROUT | YIN, 5'd0));
        sb.push_back(ev(GRC | ROUT | ZIN, 5'b00100));
        sb.push_back(ev(ZLOW | GRA | RIN, 5'd0));
        exec(mk_ir(5'b00100), 1'b0, "sub");

        for (int c = 0; c < 2; c++) begin
            push_fetch();
            sb.push_back(ev(GRA | ROUT | CONIN, 5'd0));
            sb.push_back(ev(PCOUT | YIN, 5'd0));
            sb.push_back(ev(COUT | ZIN, ADD));
            sb.push_back(ev(ZLOW | (c == 1 ? PCIN : 20'h0), 5'd0));
            exec(mk_ir(5'b10010), c[0], c == 1 ? "br_taken" : "br_not_taken");
        end

        // undefined opcode behaves as nop
        push_fetch();
        sb.push_back(ev(20'h0, 5'd0));
        exec(mk_ir(5'b11111), 1'b0, "undef");

        // ld interrupted by clear in the middle of T5
        push_fetch();
        sb.push_back(ev(GRB | BAOUT | YIN, 5'd0));
        sb.push_back(ev(COUT | ZIN, ADD));
        sb.push_back(ev(ZLOW | MARIN, 5'd0));
        exec(mk_ir(5'b00000), 1'b0, "ld");
        #1 clear = 1'b0;
        #1 chk("ld_async_clear", OFF);
        @(negedge Clock); clear = 1'b1;

        // addi with Stop held: completes, then HALT
        Stop = 1'b1;
        push_fetch();
        sb.push_back(ev(GRB | ROUT | YIN, 5'd0));
        sb.push_back(ev(COUT | ZIN, ADD));
        sb.push_back(ev(ZLOW | GRA | RIN, 5'd0));
        push_off(10);
        exec(mk_ir(5'b01100), 1'b0, "addi_stop");
        Stop = 1'b0;
        clear_pulse("halt_clear");

        // halt opcode: T3 then HALT
        push_fetch();
        sb.push_back(ev(20'h0, 5'd0));
        push_off(10);
        exec(mk_ir(5'b11011), 1'b0, "halt_op");
        clear_pulse("halt_op_clear");

        // ldi after clear: T0 one cycle after release
        push_fetch();
        sb.push_back(ev(GRB | BAOUT | YIN, 5'd0));
        sb.push_back(ev(COUT | ZIN, ADD));
        sb.push_back(ev(ZLOW | GRA | RIN, 5'd0));
        sb.push_back(ev(PCOUT | MARIN | INCPC | ZIN, 5'd0));
        exec(mk_ir(5'b00001), 1'b0, "ldi");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
